// File: rtl/ahblite_lcd_rd_engine_if.sv
// AHB-lite slave-side signal bundle for the LCD read engine.
interface ahblite_lcd_rd_engine_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahblite_lcd_rd_engine.sv
// AHB-lite slave running hardware-timed 8080 LCD read cycles with wait states.
// Optional LCD_RD_SYNC_EN: 2-flop synchronizer on LCD_DATA_IN, strobe stretched by 2 cycles.
module ahblite_lcd_rd_engine #(
    parameter int unsigned RD_LOW_DEF  = 4,
    parameter int unsigned RD_HIGH_DEF = 2
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    ahblite_lcd_rd_engine_if.slave        bus,
    output logic                          LCD_CS,
    output logic                          LCD_RS,
    output logic                          LCD_RD,
    input  logic [15:0]                   LCD_DATA_IN,
    output logic                          LCD_RD_ACTIVE
);
    localparam int unsigned CNT_W = 9;
`ifdef LCD_RD_SYNC_EN
    localparam int unsigned SYNC_EXTRA = 2;
`else
    localparam int unsigned SYNC_EXTRA = 0;
`endif
    localparam logic [5:0] IDX_TIMING = 6'h00;
    localparam logic [5:0] IDX_STATUS = 6'h01;
    localparam logic [5:0] IDX_RDATA  = 6'h02;
    localparam logic [5:0] IDX_RSTAT  = 6'h03;
    localparam logic [5:0] IDX_LAST   = 6'h04;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;
    state_t state, state_nxt;

    logic [15:0]      timing_q, last_q, count_q, cap_data_c, timing_eff_c;
    logic [CNT_W-1:0] low_cnt_q;
    logic [7:0]       rec_cnt_q, rd_low_eff_c;
    logic             pend_q, pend_rs_q;
    logic             dp_valid_q, dp_write_q;
    logic [5:0]       dp_idx_q, idx_c;
    logic             hreadyout_q;
    logic [31:0]      hrdata_q, rd_mux_c;
    logic             acc_c, trig_c, trig_rs_c, tim_wr_c, capture_c;
    logic             unused_ok;

    assign idx_c        = bus.HADDR[7:2];
    assign acc_c        = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign trig_c       = acc_c & ~bus.HWRITE & ((idx_c == IDX_RDATA) | (idx_c == IDX_RSTAT));
    assign trig_rs_c    = (idx_c == IDX_RDATA);
    assign tim_wr_c     = dp_valid_q & dp_write_q & (dp_idx_q == IDX_TIMING);
    assign timing_eff_c = tim_wr_c ? bus.HWDATA[15:0] : timing_q;
    assign rd_low_eff_c = (timing_q[7:0] == 8'd0) ? 8'd1 : timing_q[7:0];

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.HRESP     = 1'b0;

    assign unused_ok = ^{bus.HADDR[31:8], bus.HADDR[1:0], bus.HTRANS[0],
                         bus.HSIZE, bus.HPROT, bus.HWDATA[31:16]};

`ifdef LCD_RD_SYNC_EN
    logic [15:0] sync1_q, sync2_q;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= LCD_DATA_IN;
            sync2_q <= sync1_q;
        end
    end
    assign cap_data_c = sync2_q;
`else
    assign cap_data_c = LCD_DATA_IN;
`endif

    // Register read mux; a TIMING write still in its data phase is forwarded
    always_comb begin
        rd_mux_c = '0;
        case (idx_c)
            IDX_TIMING: rd_mux_c = {16'h0, timing_eff_c};
            IDX_STATUS: rd_mux_c = {count_q, 15'h0, state != IDLE};
            IDX_LAST:   rd_mux_c = {16'h0, last_q};
            default:    rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture_c = 1'b0;
        case (state)
            IDLE:    if (trig_c) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (low_cnt_q == '0) begin
                         capture_c = 1'b1;
                         state_nxt = (rec_cnt_q != 8'd0) ? RECOVER : IDLE;
                     end
            // A read accepted during recovery waits out the remaining cycles with CS held low
            RECOVER: if (rec_cnt_q == 8'd0) state_nxt = (pend_q | trig_c) ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q    <= 1'b0;
            dp_write_q    <= 1'b0;
            dp_idx_q      <= '0;
            timing_q      <= {8'(RD_HIGH_DEF), 8'(RD_LOW_DEF)};
            low_cnt_q     <= '0;
            rec_cnt_q     <= '0;
            pend_q        <= 1'b0;
            pend_rs_q     <= 1'b1;
            last_q        <= '0;
            count_q       <= '0;
            hreadyout_q   <= 1'b1;
            hrdata_q      <= '0;
            LCD_CS        <= 1'b1;
            LCD_RS        <= 1'b1;
            LCD_RD        <= 1'b1;
            LCD_RD_ACTIVE <= 1'b0;
        end else begin
            dp_valid_q <= acc_c;
            dp_write_q <= bus.HWRITE;
            dp_idx_q   <= idx_c;
            if (tim_wr_c) timing_q <= bus.HWDATA[15:0];

            // Timing is sampled at the end of SETUP so a just-completed write is honoured
            if (state == SETUP) begin
                low_cnt_q <= CNT_W'(rd_low_eff_c) + CNT_W'(SYNC_EXTRA) - CNT_W'(1);
                rec_cnt_q <= timing_q[15:8];
            end else if (state == STROBE && low_cnt_q != '0) begin
                low_cnt_q <= low_cnt_q - CNT_W'(1);
            end else if (state == RECOVER && rec_cnt_q != 8'd0) begin
                rec_cnt_q <= rec_cnt_q - 8'd1;
            end

            if (state_nxt == SETUP) begin
                pend_q <= 1'b0;
            end else if (trig_c && state == RECOVER) begin
                pend_q    <= 1'b1;
                pend_rs_q <= trig_rs_c;
            end

            if (trig_c)         hreadyout_q <= 1'b0;
            else if (capture_c) hreadyout_q <= 1'b1;

            if (capture_c) begin
                last_q   <= cap_data_c;
                count_q  <= count_q + 16'd1;
                hrdata_q <= {16'h0, cap_data_c};
            end else if (acc_c && !bus.HWRITE && !trig_c) begin
                hrdata_q <= rd_mux_c;
            end

            LCD_CS        <= (state_nxt == IDLE);
            LCD_RD        <= (state_nxt != STROBE);
            LCD_RD_ACTIVE <= (state_nxt != IDLE);
            if (state_nxt == SETUP && state != SETUP) LCD_RS <= pend_q ? pend_rs_q : trig_rs_c;
        end
    end
endmodule

// File: tb/tb_ahblite_lcd_rd_engine.sv
// Directed self-checking bench for ahblite_lcd_rd_engine (honours LCD_RD_SYNC_EN).
module tb_ahblite_lcd_rd_engine;
`ifdef LCD_RD_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [15:0] LCD_DATA_IN;
    logic        LCD_CS, LCD_RS, LCD_RD, LCD_RD_ACTIVE;
    int          n_chk = 0;
    int          n_fail = 0;

    ahblite_lcd_rd_engine_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    ahblite_lcd_rd_engine dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .bus           (bus),
        .LCD_CS        (LCD_CS),
        .LCD_RS        (LCD_RS),
        .LCD_RD        (LCD_RD),
        .LCD_DATA_IN   (LCD_DATA_IN),
        .LCD_RD_ACTIVE (LCD_RD_ACTIVE)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One read transfer; reports data, stall length, RD-low cycles, CS-high cycles in the stall, RS during RD
    task automatic ahb_read(input logic [5:0] idx, input bit b2b, output logic [31:0] data,
                            output int stall, output int rd_low, output int cs_hi, output logic rs);
        if (!b2b) @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = {24'h0, idx, 2'b00};
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        stall = 0; rd_low = 0; cs_hi = 0; rs = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge HCLK);
            if (bus.HREADYOUT) break;
            stall++;
            if (!LCD_RD) begin rd_low++; rs = LCD_RS; end
            if (LCD_CS) cs_hi++;
        end
        data = bus.HRDATA;
    endtask

    task automatic ahb_write(input logic [5:0] idx, input logic [31:0] d, output int stall);
        @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = {24'h0, idx, 2'b00};
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = d;
        stall = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge HCLK);
            if (bus.HREADYOUT) break;
            stall++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int          st, rl, ch;
        logic        rs;

        HRESETn = 1'b0; LCD_DATA_IN = 16'h0;
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010;
        bus.HPROT = 4'h3; bus.HWRITE = 1'b0; bus.HWDATA = '0;
        repeat (3) @(negedge HCLK);
        chk("rst_lcd_pins", {28'h0, LCD_CS, LCD_RS, LCD_RD, LCD_RD_ACTIVE}, 32'hE);
        chk("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_hresp", {31'h0, bus.HRESP}, 32'h0);
        HRESETn = 1'b1;

        ahb_read(6'h01, 1'b0, d, st, rl, ch, rs);  chk("rst_status", d, 32'h0);
        chk("status_zero_wait", 32'(st), 32'h0);
        ahb_read(6'h00, 1'b0, d, st, rl, ch, rs);  chk("rst_timing", d, 32'h0204);
        ahb_read(6'h04, 1'b0, d, st, rl, ch, rs);  chk("rst_last", d, 32'h0);

        // Default timing RDATA read
        LCD_DATA_IN = 16'hA5C3;
        ahb_read(6'h02, 1'b0, d, st, rl, ch, rs);
        chk("t1_data", d, 32'h0000A5C3);
        chk("t1_stall", 32'(st), 32'(5 + SX));
        chk("t1_rd_low", 32'(rl), 32'(4 + SX));
        chk("t1_rs", {31'h0, rs}, 32'h1);
        chk("t1_cs_low", 32'(ch), 32'h0);
        ahb_read(6'h01, 1'b0, d, st, rl, ch, rs);  chk("t1_status_busy", d, 32'h00010001);
        ahb_read(6'h04, 1'b0, d, st, rl, ch, rs);  chk("t1_last", d, 32'h0000A5C3);
        repeat (3) @(negedge HCLK);
        chk("t1_idle_pins", {30'h0, LCD_CS, LCD_RD_ACTIVE}, 32'h2);

        // Zero widths: RD low treated as 1, no recovery
        ahb_write(6'h00, 32'h0, st);                chk("t3_wr_zero_wait", 32'(st), 32'h0);
        LCD_DATA_IN = 16'h1234;
        ahb_read(6'h03, 1'b0, d, st, rl, ch, rs);
        chk("t3_data", d, 32'h00001234);
        chk("t3_stall", 32'(st), 32'(2 + SX));
        chk("t3_rd_low", 32'(rl), 32'(1 + SX));
        chk("t3_rs", {31'h0, rs}, 32'h0);
        chk("t3_no_recover", {30'h0, LCD_CS, LCD_RD_ACTIVE}, 32'h2);

        // Back-to-back with RD_LOW=2, RD_HIGH=3
        ahb_write(6'h00, 32'h0302, st);
        ahb_read(6'h00, 1'b0, d, st, rl, ch, rs);  chk("t4_timing", d, 32'h0302);
        LCD_DATA_IN = 16'h1111;
        ahb_read(6'h02, 1'b0, d, st, rl, ch, rs);
        chk("t4_first_data", d, 32'h00001111);
        chk("t4_first_stall", 32'(st), 32'(3 + SX));
        chk("t4_cs_between", {31'h0, LCD_CS}, 32'h0);
        LCD_DATA_IN = 16'h2222;
        ahb_read(6'h02, 1'b1, d, st, rl, ch, rs);
        chk("t4_second_data", d, 32'h00002222);
        chk("t4_second_stall", 32'(st), 32'(6 + SX));
        chk("t4_second_rd_low", 32'(rl), 32'(2 + SX));
        chk("t4_cs_held", 32'(ch), 32'h0);
        repeat (6) @(negedge HCLK);
        ahb_read(6'h01, 1'b0, d, st, rl, ch, rs);  chk("t4_count", d, 32'h00040000);

        // Reset asserted mid-strobe
        @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'h8;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        @(negedge HCLK); @(negedge HCLK);
        chk("t5_in_strobe", {31'h0, LCD_RD}, 32'h0);
        #2 HRESETn = 1'b0;
        #1;
        chk("t5_async_pins", {29'h0, LCD_CS, LCD_RD, LCD_RD_ACTIVE}, 32'h6);
        chk("t5_async_hready", {31'h0, bus.HREADYOUT}, 32'h1);
        @(negedge HCLK); HRESETn = 1'b1;
        ahb_read(6'h01, 1'b0, d, st, rl, ch, rs);  chk("t5_status", d, 32'h0);
        ahb_read(6'h04, 1'b0, d, st, rl, ch, rs);  chk("t5_last", d, 32'h0);
        ahb_read(6'h00, 1'b0, d, st, rl, ch, rs);  chk("t5_timing", d, 32'h0204);

        // Count wrap, ignored RO write, unmapped read
        @(negedge HCLK);
        force dut.count_q = 16'hFFFF;
        @(negedge HCLK);
        release dut.count_q;
        ahb_read(6'h01, 1'b0, d, st, rl, ch, rs);  chk("t6_count_preset", d, 32'hFFFF0000);
        LCD_DATA_IN = 16'hBEEF;
        ahb_read(6'h02, 1'b0, d, st, rl, ch, rs);  chk("t6_data", d, 32'h0000BEEF);
        repeat (4) @(negedge HCLK);
        ahb_read(6'h01, 1'b0, d, st, rl, ch, rs);  chk("t6_count_wrap", d, 32'h0);
        ahb_write(6'h04, 32'h00001234, st);         chk("t6_ro_wr_zero_wait", 32'(st), 32'h0);
        ahb_read(6'h04, 1'b0, d, st, rl, ch, rs);  chk("t6_last_kept", d, 32'h0000BEEF);
        ahb_read(6'h10, 1'b0, d, st, rl, ch, rs);  chk("t6_unmapped", d, 32'h0);
        chk("t6_unmapped_wait", 32'(st), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
